// File: rtl/seven_seg_to_binary.sv
// -----------------------------------------------------------------------------
// seven_seg_to_binary
//
// Converts a pair of active-low seven-segment digit patterns (tens, ones) into
// a 7-bit binary value 0..99. The conversion runs as a small multi-cycle FSM:
// the pair is captured on accept, both digits are looked up in one DECODE
// cycle, and the tens digit is folded in by repeated addition of 10 (one ACC
// cycle per tens unit). The result is presented with a valid/ready handshake.
//
// Segment encoding: bit 0 = segment a ... bit 6 = segment g, 0 = lit.
//
// Parameters
//   BLANK_TENS_OK : 1 = an all-off tens pattern (7'b1111111) decodes as 0,
//                   0 = it is an illegal pattern.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high reset
//   h0        in   ones-digit segment pattern [0:6]
//   h1        in   tens-digit segment pattern [0:6]
//   in_valid  in   h1/h0 hold a pair to convert
//   in_ready  out  a pair can be accepted this cycle
//   y         out  binary value of the last decoded pair
//   err       out  last result came from an illegal pattern
//   out_valid out  y/err hold a result
//   out_ready in   consumer takes the result this cycle
// -----------------------------------------------------------------------------
module seven_seg_to_binary #(
   parameter bit BLANK_TENS_OK = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [0:6] h0,
   input  logic [0:6] h1,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [6:0] y,
   output logic       err,
   output logic       out_valid,
   input  logic       out_ready
);

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      ACC,
      DONE
   } state_e;

   typedef struct packed {
      logic       legal;
      logic [3:0] value;
   } digit_t;

   // Pattern literals are written bit 0 (segment a) first, which matches the
   // [0:6] ordering of the segment vectors.
   function automatic digit_t decode_digit(input logic [0:6] seg,
                                           input logic       blank_ok);
      digit_t d;
      d.legal = 1'b1;
      d.value = 4'd0;
      case (seg)
         7'b0000001: d.value = 4'd0;
         7'b1001111: d.value = 4'd1;
         7'b0010010: d.value = 4'd2;
         7'b0000110: d.value = 4'd3;
         7'b1001100: d.value = 4'd4;
         7'b0100100: d.value = 4'd5;
         7'b0100000: d.value = 4'd6;
         7'b0001111: d.value = 4'd7;
         7'b0000000: d.value = 4'd8;
         7'b0000100: d.value = 4'd9;
         7'b1111111: d.legal = blank_ok;   // blank digit reads as 0 if allowed
         default:    d.legal = 1'b0;
      endcase
      return d;
   endfunction

   state_e     state_q, state_d;
   logic [0:6] h1_q, h1_d;
   logic [0:6] h0_q, h0_d;
   logic [6:0] acc_q, acc_d;
   logic [3:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   digit_t     tens;
   digit_t     ones;

   assign tens = decode_digit(h1_q, BLANK_TENS_OK);
   assign ones = decode_digit(h0_q, 1'b0);

   // in_ready is forced low while reset is asserted, not just once the state
   // register has been cleared.
   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = (state_q == DONE);
   assign y         = acc_q;
   assign err       = err_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      h1_d    = h1_q;
      h0_d    = h0_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               h1_d    = h1;
               h0_d    = h0;
               state_d = DECODE;
            end
         end

         DECODE: begin
            if (!tens.legal || !ones.legal) begin
               err_d   = 1'b1;
               acc_d   = 7'd0;
               cnt_d   = 4'd0;
               state_d = DONE;
            end else begin
               err_d   = 1'b0;
               acc_d   = {3'b000, ones.value};
               cnt_d   = tens.value;
               state_d = (tens.value == 4'd0) ? DONE : ACC;
            end
         end

         ACC: begin
            // Ones <= 9 plus at most nine additions of 10 stays within 99.
            acc_d = acc_q + 7'd10;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      if (reset) begin
         state_q <= IDLE;
         h1_q    <= '0;
         h0_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         h1_q    <= h1_d;
         h0_q    <= h0_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/seven_seg_to_binary.md
SEVEN_SEG_TO_BINARY -- requirements
Module: seven_seg_to_binary

Interface
REQ-001 Parameter BLANK_TENS_OK, default 1; 1 = all-segments-off tens pattern (7'b1111111) is accepted as tens digit 0, 0 = it is illegal.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 h0  input  [0:6]  ones-digit segment pattern, bit 0 = segment a ... bit 6 = segment g, active-low (0 = lit).
REQ-005 h1  input  [0:6]  tens-digit segment pattern, same encoding as h0.
REQ-006 in_valid  input  1  h1/h0 hold a pattern pair to convert.
REQ-007 in_ready  output  1  block can accept a pattern pair this cycle.
REQ-008 y  output  [6:0]  binary value 0..99 of the decoded pair.
REQ-009 err  output  1  last result came from an illegal pattern.
REQ-010 out_valid  output  1  y/err hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.

Function
REQ-012 Legal digit patterns (bit 0 first) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; every other pattern is illegal, except REQ-001 for h1.
REQ-013 FSM states SHALL be IDLE, DECODE, ACC, DONE; in_ready = (state==IDLE) and reset low; out_valid = (state==DONE).
REQ-014 IDLE: on edge with in_valid && in_ready, h1/h0 SHALL be captured into internal registers and the state SHALL go to DECODE; otherwise the state SHALL stay in IDLE.
REQ-015 Input patterns SHALL be sampled only at the accept edge; later changes on h1/h0 SHALL NOT affect the result in flight.
REQ-016 DECODE (one cycle): both captured digits SHALL be looked up; if either is illegal, err SHALL be set to 1, y SHALL be set to 0, and the state SHALL go to DONE.
REQ-017 DECODE, both legal: the accumulator SHALL be loaded with ones and the count with tens, and err SHALL be set to 0; if tens==0 the state SHALL go to DONE, otherwise to ACC.
REQ-018 ACC: each cycle the accumulator SHALL add 10 (7-bit, never overflows, max 99) and the count SHALL decrement; when the count reaches 0 the state SHALL go to DONE.
REQ-019 Latency from accept edge to out_valid high SHALL be 2 cycles for illegal input or tens==0, and 2+tens cycles otherwise (max 11).
REQ-020 DONE: y/err SHALL equal the final result and SHALL be stable while out_valid is high; on edge with out_ready high the state SHALL go to IDLE.
REQ-021 No new pair SHALL be accepted in the same cycle a result is consumed; the next accept is possible no earlier than 1 cycle after consumption.
REQ-022 y and err SHALL hold their last values after consumption until the next DECODE/ACC update.
REQ-023 out_ready while not in DONE SHALL be ignored; in_valid while not in IDLE SHALL be ignored (no queuing).

Reset
REQ-024 On any edge with reset high, the state SHALL go to IDLE, y=0, err=0, out_valid=0, accumulator/count=0, regardless of current state (including mid-ACC).
REQ-025 While reset is high, in_ready SHALL be 0; on the first cycle after reset is low, in_ready SHALL be 1.
REQ-026 A conversion interrupted by reset SHALL produce no out_valid pulse.

Verification
REQ-027 h1=0000001, h0=0001111, accepted at edge T -> out_valid high at T+2, y=7, err=0.
REQ-028 h1=1001111, h0=0100100 -> y=15, err=0, out_valid at T+3; h1=0000100, h0=0000100 -> y=99, out_valid at T+11.
REQ-029 h0=1111110 (illegal) -> err=1, y=0 at T+2; h1=1111111, h0=0010010 -> y=2, err=0 when BLANK_TENS_OK=1, and err=1 when BLANK_TENS_OK=0.
REQ-030 out_ready held low 5 cycles in DONE -> out_valid, y, err stable; in_ready=0 throughout; h1/h0 changed after accept -> result unchanged.
REQ-031 reset pulsed during ACC of the 99 case -> next cycle out_valid=0, y=0, err=0; in_ready=1 after reset drops, and a fresh 42 converts to y=42.
